// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer: operand-side driver for a 3-stage pipelined signed 8x8 MAC.
// Holds two 8-bit operand vectors. On start it clears the MAC, streams one pair
// per cycle, waits for the pipeline to drain and captures the 16-bit dot product.
module mac_dot_sequencer #(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int PIPE_LAT = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_a,
  input  logic [7:0]    wr_b,
  input  logic          start,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic [15:0]   result,
  output logic          mac_reset,
  output logic [7:0]    mac_a,
  output logic [7:0]    mac_b,
  input  logic [15:0]   mac_f
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CLEAR  = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  localparam logic [AW:0] DEPTH_L      = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_L        = (AW+1)'(1);
  localparam logic [AW:0] DRAIN_LAST_L = (AW+1)'(PIPE_LAT - 1);

  logic [7:0]    vec_a_q [DEPTH];
  logic [7:0]    vec_b_q [DEPTH];

  logic [1:0]    state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   len_q, len_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [15:0]   result_q, result_d;

  logic          wr_ok_s;
  logic [AW:0]   len_sel_s;
  logic [AW-1:0] rd_idx_s;

  // Writes only land while idle and only into entries that exist.
  assign wr_ok_s   = wr_en & ~busy_q & ({1'b0, wr_addr} < DEPTH_L);
  assign len_sel_s = (len > DEPTH_L) ? DEPTH_L : len;
  assign rd_idx_s  = cnt_q[AW-1:0];

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  // MAC is held cleared during our own reset as well as for the CLEAR cycle.
  assign mac_reset = reset | (state_q == S_CLEAR);

  // Operand storage, deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      vec_a_q[wr_addr] <= wr_a;
      vec_b_q[wr_addr] <= wr_b;
    end
  end

  // Drive operands only while streaming, zeros otherwise so the MAC adds nothing.
  always_comb begin
    mac_a = 8'h00;
    mac_b = 8'h00;
    if (!reset && (state_q == S_STREAM)) begin
      mac_a = vec_a_q[rd_idx_s];
      mac_b = vec_b_q[rd_idx_s];
    end else begin
      mac_a = 8'h00;
      mac_b = 8'h00;
    end
  end

  // Sequencer next-state: CLEAR -> STREAM (len cycles) -> DRAIN (PIPE_LAT cycles).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = len_sel_s;
          cnt_d   = '0;
          state_d = S_CLEAR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        cnt_d = '0;
        if (len_q != '0) begin
          state_d = S_STREAM;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_STREAM: begin
        if (cnt_q == (len_q - ONE_L)) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + ONE_L;
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST_L) begin
          cnt_d    = '0;
          state_d  = S_IDLE;
          done_d   = 1'b1;
          result_d = mac_f;
        end else begin
          cnt_d = cnt_q + ONE_L;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Sequencer state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Bench for mac_dot_sequencer: behavioural 3-stage MAC, shadow operand arrays
// and a scoreboard queue of expected dot products and latencies.
module tb_mac_dot_sequencer;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_a;
  logic [7:0]  wr_b;
  logic        start;
  logic [4:0]  len;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        mac_reset;
  logic [7:0]  mac_a;
  logic [7:0]  mac_b;
  logic [15:0] mac_f;

  int total;
  int bad;

  logic signed [7:0] sh_a [16];
  logic signed [7:0] sh_b [16];
  logic [15:0]       exp_q [$];
  int                lat_q [$];

  // MAC model: operand regs, product reg, accumulator
  logic signed [7:0]  m_a_r;
  logic signed [7:0]  m_b_r;
  logic signed [15:0] m_p_r;
  logic signed [15:0] m_f_r;

  mac_dot_sequencer #(.DEPTH(16), .AW(4), .PIPE_LAT(3)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_a(wr_a), .wr_b(wr_b), .start(start), .len(len),
    .busy(busy), .done(done), .result(result), .mac_reset(mac_reset),
    .mac_a(mac_a), .mac_b(mac_b), .mac_f(mac_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference MAC pipeline
  always_ff @(posedge clk) begin
    if (mac_reset) begin
      m_a_r <= 8'sd0;
      m_b_r <= 8'sd0;
      m_p_r <= 16'sd0;
      m_f_r <= 16'sd0;
    end else begin
      m_a_r <= mac_a;
      m_b_r <= mac_b;
      m_p_r <= m_a_r * m_b_r;
      m_f_r <= m_f_r + m_p_r;
    end
  end
  assign mac_f = m_f_r;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input int a, input int b);
    wr_en   = 1'b1;
    wr_addr = addr[3:0];
    wr_a    = a[7:0];
    wr_b    = b[7:0];
    sh_a[addr] = a[7:0];
    sh_b[addr] = b[7:0];
    tick;
    wr_en = 1'b0;
  endtask

  task automatic run_dot(input string tag, input int l, input int extra_start_n,
                         input int drop_wr_n, output bit saw_nonzero);
    int eff;
    int sum;
    int n;
    int busy_cycles;
    int extra_done;
    bit seen;
    logic [15:0] exp_r;
    int exp_lat;
    eff = (l > 16) ? 16 : l;
    sum = 0;
    for (int i = 0; i < eff; i++) sum += int'(sh_a[i]) * int'(sh_b[i]);
    exp_q.push_back(sum[15:0]);
    lat_q.push_back(eff + 4);
    saw_nonzero = 1'b0;
    start = 1'b1;
    len   = l[4:0];
    tick;
    start = 1'b0;
    len   = 5'd0;
    n = 0;
    busy_cycles = 0;
    seen = 1'b0;
    while (n < 64 && !seen) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) busy_cycles++;
        if (mac_a != 8'h00 || mac_b != 8'h00) saw_nonzero = 1'b1;
        if (n == extra_start_n) begin
          start = 1'b1;
          len   = 5'd1;
        end
        if (n == drop_wr_n) begin
          wr_en   = 1'b1;
          wr_addr = 4'd0;
          wr_a    = 8'd100;
          wr_b    = 8'd100;
        end
        tick;
        start = 1'b0;
        wr_en = 1'b0;
        n++;
      end
    end
    exp_r   = exp_q.pop_front();
    exp_lat = lat_q.pop_front();
    if (!seen) begin
      check_eq({tag, "_done_timeout"}, 32'd0, 32'd1);
    end else begin
      check_eq({tag, "_result"}, 32'(result), 32'(exp_r));
      check_eq({tag, "_latency"}, 32'(n), 32'(exp_lat));
      check_eq({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(exp_lat));
      check_eq({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      extra_done = 0;
      for (int k = 0; k < 8; k++) begin
        tick;
        if (done) extra_done++;
      end
      check_eq({tag, "_single_done"}, 32'(extra_done), 32'd0);
      check_eq({tag, "_result_hold"}, 32'(result), 32'(exp_r));
    end
  endtask

  initial begin
    bit nz;
    int dcount;
    total   = 0;
    bad     = 0;
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_addr = 4'd0;
    wr_a    = 8'd0;
    wr_b    = 8'd0;
    start   = 1'b0;
    len     = 5'd0;
    tick;
    tick;
    check_eq("rst_mac_reset", 32'(mac_reset), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_result", 32'(result), 32'd0);
    check_eq("rst_mac_a", 32'(mac_a), 32'd0);
    reset = 1'b0;
    tick;
    check_eq("idle_mac_reset", 32'(mac_reset), 32'd0);

    // Small mixed-sign vector with an ignored start and a dropped write mid-run
    wr(0, 1, 2);
    wr(1, -3, 4);
    wr(2, 2, 8);
    run_dot("t1", 3, 2, 3, nz);
    run_dot("t1_rerun", 3, -1, -1, nz);

    // Zero length: result cleared, no operands ever presented
    run_dot("len0", 0, -1, -1, nz);
    check_eq("len0_ops_zero", 32'(nz), 32'd0);

    // Wrap-around cases
    for (int i = 0; i < 4; i++) wr(i, -128, -128);
    run_dot("wrap4", 4, -1, -1, nz);
    run_dot("wrap2", 2, -1, -1, nz);

    // Clamp len above DEPTH
    for (int i = 0; i < 16; i++) wr(i, 1, 1);
    run_dot("clamp20", 20, -1, -1, nz);
    run_dot("full16", 16, -1, -1, nz);

    // Reset in the middle of STREAM
    start = 1'b1;
    len   = 5'd8;
    tick;
    start = 1'b0;
    len   = 5'd0;
    tick;
    tick;
    tick;
    reset = 1'b1;
    tick;
    check_eq("abort_mac_reset", 32'(mac_reset), 32'd1);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_result", 32'(result), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    reset = 1'b0;
    dcount = 0;
    for (int k = 0; k < 16; k++) begin
      tick;
      if (done) dcount++;
    end
    check_eq("abort_no_done", 32'(dcount), 32'd0);
    check_eq("abort_result_kept", 32'(result), 32'd0);
    run_dot("after_abort", 8, -1, -1, nz);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
